// File: rtl/uart_word_bridge.sv
// Packs UART RX bytes into RAM words (capture) and streams RAM words
// back out through the UART TX core byte by byte (playback), LSB first.
module uart_word_bridge #(
    parameter int BYTE_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int ADDR_W     = 12,
    parameter int NUM_WORDS  = 768,
    localparam int WORD_W    = BYTE_W * WORD_BYTES
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              CMD_RX,
    input  logic              CMD_TX,
    input  logic              CMD_STOP,
    input  logic [BYTE_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic [BYTE_W-1:0] TX_DATA,
    output logic              TX_START,
    input  logic              TX_BUSY,
    output logic [ADDR_W-1:0] WR_ADDR,
    output logic [WORD_W-1:0] WR_DATA,
    output logic              WR_EN,
    output logic [ADDR_W-1:0] RD_ADDR,
    output logic              RD_EN,
    input  logic [WORD_W-1:0] RD_Q,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W:0]   WORD_CNT
);

    localparam int BI_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [BI_W-1:0] LP_LAST_BYTE = BI_W'(WORD_BYTES - 1);
    localparam logic [ADDR_W:0] LP_LAST_WORD = (ADDR_W + 1)'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RX_COLLECT,
        TX_FETCH,
        TX_WAITQ,
        TX_LOAD,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [BI_W-1:0]     r_byte_idx;
    logic [ADDR_W:0]     r_word_cnt;
    logic [WORD_W-1:0]   r_shift;
    logic [1:0]          r_wait;
    logic [BYTE_W-1:0]   r_tx_data;
    logic                r_tx_start;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WORD_W-1:0]   r_wr_data;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_rd_addr;
    logic                r_rd_en;
    logic                r_done;

    logic                w_last_byte;
    logic                w_last_word;
    logic [WORD_W-1:0]   w_packed;
    logic [BYTE_W-1:0]   w_tx_lane;

    assign w_last_byte = (r_byte_idx == LP_LAST_BYTE);
    assign w_last_word = (r_word_cnt == LP_LAST_WORD);
    assign w_tx_lane   = r_shift[r_byte_idx * BYTE_W +: BYTE_W];

    // Shift register with the incoming byte merged into its lane
    always_comb begin
        w_packed = r_shift;
        w_packed[r_byte_idx * BYTE_W +: BYTE_W] = RX_DATA;
    end

    always_comb begin
        w_next = r_state;
        if (CMD_STOP) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (CMD_RX)      w_next = RX_COLLECT;
                    else if (CMD_TX) w_next = TX_FETCH;
                end
                RX_COLLECT: begin
                    if (RX_VALID && w_last_byte && w_last_word)
                        w_next = IDLE;
                end
                TX_FETCH: w_next = TX_WAITQ;
                TX_WAITQ: begin
                    if (r_wait == 2'd2) w_next = TX_LOAD;
                end
                TX_LOAD: begin
                    if (!TX_BUSY) w_next = TX_WAIT_HI;
                end
                TX_WAIT_HI: begin
                    if (TX_BUSY) w_next = TX_WAIT_LO;
                end
                TX_WAIT_LO: begin
                    if (!TX_BUSY) begin
                        if (!w_last_byte)     w_next = TX_LOAD;
                        else if (w_last_word) w_next = IDLE;
                        else                  w_next = TX_FETCH;
                    end
                end
                default: w_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state    <= IDLE;
            r_byte_idx <= '0;
            r_word_cnt <= '0;
            r_shift    <= '0;
            r_wait     <= '0;
            r_tx_data  <= '0;
            r_tx_start <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_wr_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_en    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= 1'b0;
            r_wr_en    <= 1'b0;
            r_rd_en    <= 1'b0;
            r_done     <= 1'b0;
            if (CMD_STOP) begin
                r_byte_idx <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (CMD_RX || CMD_TX) begin
                            r_word_cnt <= '0;
                            r_byte_idx <= '0;
                            r_shift    <= '0;
                        end
                    end
                    RX_COLLECT: begin
                        if (RX_VALID) begin
                            if (w_last_byte) begin
                                r_wr_en    <= 1'b1;
                                r_wr_addr  <= r_word_cnt[ADDR_W-1:0];
                                r_wr_data  <= w_packed;
                                r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
                                r_byte_idx <= '0;
                                r_shift    <= '0;
                                r_done     <= w_last_word;
                            end else begin
                                r_shift    <= w_packed;
                                r_byte_idx <= r_byte_idx + BI_W'(1);
                            end
                        end
                    end
                    TX_FETCH: begin
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= r_word_cnt[ADDR_W-1:0];
                        r_wait    <= '0;
                    end
                    // RAM registers address then data: q is usable two cycles on
                    TX_WAITQ: begin
                        if (r_wait == 2'd2) begin
                            r_shift    <= RD_Q;
                            r_byte_idx <= '0;
                        end else begin
                            r_wait <= r_wait + 2'd1;
                        end
                    end
                    TX_LOAD: begin
                        if (!TX_BUSY) begin
                            r_tx_data  <= w_tx_lane;
                            r_tx_start <= 1'b1;
                        end
                    end
                    TX_WAIT_LO: begin
                        if (!TX_BUSY) begin
                            if (!w_last_byte) begin
                                r_byte_idx <= r_byte_idx + BI_W'(1);
                            end else begin
                                r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
                                r_done     <= w_last_word;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign TX_DATA  = r_tx_data;
    assign TX_START = r_tx_start;
    assign WR_ADDR  = r_wr_addr;
    assign WR_DATA  = r_wr_data;
    assign WR_EN    = r_wr_en;
    assign RD_ADDR  = r_rd_addr;
    assign RD_EN    = r_rd_en;
    assign DONE     = r_done;
    assign WORD_CNT = r_word_cnt;
    assign BUSY     = (r_state != IDLE);

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge with a 2-cycle RAM model and a
// simple TX core model that holds busy for a few cycles per byte.
module tb_uart_word_bridge;

    localparam int BYTE_W = 8;
    localparam int WB     = 4;
    localparam int AW     = 4;
    localparam int NW     = 4;
    localparam int WW     = BYTE_W * WB;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_rx = 1'b0;
    logic              cmd_tx = 1'b0;
    logic              cmd_stop = 1'b0;
    logic [BYTE_W-1:0] rx_data = '0;
    logic              rx_valid = 1'b0;
    logic [BYTE_W-1:0] tx_data;
    logic              tx_start;
    logic              tx_busy = 1'b0;
    logic [AW-1:0]     wr_addr;
    logic [WW-1:0]     wr_data;
    logic              wr_en;
    logic [AW-1:0]     rd_addr;
    logic              rd_en;
    logic [WW-1:0]     rd_q = '0;
    logic              busy;
    logic              done;
    logic [AW:0]       word_cnt;

    uart_word_bridge #(
        .BYTE_W(BYTE_W), .WORD_BYTES(WB), .ADDR_W(AW), .NUM_WORDS(NW)
    ) dut (
        .CLOCK_50(clk), .RESET(rst),
        .CMD_RX(cmd_rx), .CMD_TX(cmd_tx), .CMD_STOP(cmd_stop),
        .RX_DATA(rx_data), .RX_VALID(rx_valid),
        .TX_DATA(tx_data), .TX_START(tx_start), .TX_BUSY(tx_busy),
        .WR_ADDR(wr_addr), .WR_DATA(wr_data), .WR_EN(wr_en),
        .RD_ADDR(rd_addr), .RD_EN(rd_en), .RD_Q(rd_q),
        .BUSY(busy), .DONE(done), .WORD_CNT(word_cnt)
    );

    always #5 clk = ~clk;

    logic [WW-1:0]     mem [16];
    logic [AW-1:0]     ra = '0;
    logic [AW-1:0]     wr_alog [16];
    logic [WW-1:0]     wr_dlog [16];
    logic [BYTE_W-1:0] tx_log [32];
    int wr_n = 0, done_n = 0, rd_n = 0, tx_n = 0;
    int falls = 0, falls_at_done = 0, bad_start = 0, tx_cnt = 0;
    int n_assert = 0, n_fail = 0;

    always @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
            wr_alog[wr_n[3:0]] <= wr_addr;
            wr_dlog[wr_n[3:0]] <= wr_data;
            wr_n <= wr_n + 1;
        end
        if (rd_en) begin
            ra   <= rd_addr;
            rd_n <= rd_n + 1;
        end
        rd_q <= mem[ra];
        if (done) begin
            done_n        <= done_n + 1;
            falls_at_done <= falls;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            tx_cnt  <= 0;
        end else if (tx_start) begin
            if (tx_busy) bad_start <= bad_start + 1;
            tx_log[tx_n[4:0]] <= tx_data;
            tx_n    <= tx_n + 1;
            tx_busy <= 1'b1;
            tx_cnt  <= 5;
        end else if (tx_cnt > 0) begin
            tx_cnt <= tx_cnt - 1;
            if (tx_cnt == 1) begin
                tx_busy <= 1'b0;
                falls   <= falls + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    task automatic clear_logs();
        wr_n = 0; done_n = 0; rd_n = 0; tx_n = 0;
        falls = 0; bad_start = 0;
    endtask

    logic [WW-1:0]     exp_w;
    logic [BYTE_W-1:0] exp_tx [16];
    int                snap;

    initial begin
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_done", done, 0);
        chk("rst_word_cnt", word_cnt, 0);
        rst = 1'b0;
        tick();

        // Test 1: full capture of 16 bytes
        clear_logs();
        cmd_rx = 1'b1; tick(); cmd_rx = 1'b0;
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 16; i++) send(8'(i));
        tick(); tick();
        chk("t1_wr_n", wr_n, 4);
        for (int w = 0; w < 4; w++) begin
            exp_w = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            chk($sformatf("t1_addr%0d", w), wr_alog[w], w);
            chk($sformatf("t1_data%0d", w), wr_dlog[w], exp_w);
        end
        chk("t1_done_n", done_n, 1);
        chk("t1_word_cnt", word_cnt, 4);
        chk("t1_idle", busy, 0);

        // Test 5 + 3: simultaneous commands, ignored CMD_TX, then stop
        clear_logs();
        cmd_rx = 1'b1; cmd_tx = 1'b1; tick(); cmd_rx = 1'b0; cmd_tx = 1'b0;
        chk("t5_busy", busy, 1);
        chk("t5_no_rd", rd_en, 0);
        send(8'h10); send(8'h11);
        cmd_tx = 1'b1; tick(); cmd_tx = 1'b0;
        send(8'h12); send(8'h13); send(8'h14); send(8'h15);
        chk("t5_rd_n", rd_n, 0);
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
        tick();
        chk("t3_idle", busy, 0);
        chk("t3_wr_n", wr_n, 1);
        chk("t3_addr", wr_alog[0], 0);
        chk("t3_data", wr_dlog[0], 32'h13121110);
        chk("t3_word_cnt", word_cnt, 1);
        chk("t3_done_n", done_n, 0);

        // Test 4: restart, 8 back-to-back bytes
        clear_logs();
        cmd_rx = 1'b1; tick(); cmd_rx = 1'b0;
        chk("t4_cnt_clr", word_cnt, 0);
        rx_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rx_data = 8'(8'h20 + i);
            tick();
        end
        rx_valid = 1'b0;
        tick(); tick();
        chk("t4_wr_n", wr_n, 2);
        chk("t4_addr0", wr_alog[0], 0);
        chk("t4_data0", wr_dlog[0], 32'h23222120);
        chk("t4_addr1", wr_alog[1], 1);
        chk("t4_data1", wr_dlog[1], 32'h27262524);
        chk("t4_word_cnt", word_cnt, 2);
        cmd_stop = 1'b1; tick(); cmd_stop = 1'b0;
        chk("t4_stop_idle", busy, 0);

        // Test 2: playback of 4 words
        mem[0] = 32'hDDCCBBAA;
        mem[1] = 32'h44332211;
        mem[2] = 32'h08070605;
        mem[3] = 32'hF3F2F1F0;
        exp_tx = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h05, 8'h06, 8'h07, 8'h08, 8'hF0, 8'hF1, 8'hF2, 8'hF3};
        clear_logs();
        cmd_tx = 1'b1; tick(); cmd_tx = 1'b0;
        for (int k = 0; k < 2000 && done_n == 0; k++) tick();
        chk("t2_done_seen", done_n, 1);
        chk("t2_tx_n", tx_n, 16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t2_byte%0d", i), tx_log[i], exp_tx[i]);
        chk("t2_bad_start", bad_start, 0);
        chk("t2_falls_at_done", falls_at_done, 16);
        chk("t2_rd_n", rd_n, 4);
        chk("t2_word_cnt", word_cnt, 4);
        tick();
        chk("t2_idle", busy, 0);
        chk("t2_wr_n", wr_n, 0);

        // Test 6: asynchronous reset while waiting for busy to fall
        clear_logs();
        cmd_tx = 1'b1; tick(); cmd_tx = 1'b0;
        for (int k = 0; k < 500 && !(tx_n == 3 && tx_busy); k++) tick();
        chk("t6_reach", (tx_n == 3 && tx_busy), 1);
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_tx_start", tx_start, 0);
        chk("t6_tx_data", tx_data, 0);
        chk("t6_rd_en", rd_en, 0);
        chk("t6_word_cnt", word_cnt, 0);
        tick();
        rst = 1'b0;
        snap = tx_n;
        for (int k = 0; k < 20; k++) tick();
        chk("t6_no_start", tx_n, snap);
        chk("t6_idle", busy, 0);
        chk("t6_done_n", done_n, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
